// File: rtl/npu_pkg.sv
// Shared NPU sequencer types and default sizing for one inference
// (conv1 -> NUM_CH conv2 passes -> FC1 groups -> FC2).
package npu_pkg;
  localparam int CONV_PIX   = 132;
  localparam int NUM_CH     = 10;
  localparam int FC1_GROUPS = 330;
  localparam int TIMEOUT    = 1024;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    C1_RUN   = 4'd1,
    C1_SAVE  = 4'd2,
    C2_CLR   = 4'd3,
    C2_RUN   = 4'd4,
    C2_SAVE  = 4'd5,
    FC_START = 4'd6,
    FC_LOAD  = 4'd7,
    FC_STEP  = 4'd8,
    FC_WAIT  = 4'd9,
    FC_FIN   = 4'd10,
    DONE     = 4'd11,
    ERR      = 4'd12
  } seq_state_e;
endpackage

// File: rtl/seq_watchdog.sv
// Progress watchdog: counts enabled cycles since the last kick and flags
// expiry on the TIMEOUT-th idle cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic enable,
  input  logic kick,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)              cnt <= '0;
    else if (!enable || kick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign expire = enable && !kick && (cnt == LAST);
endmodule

// File: rtl/npu_layer_sequencer.sv
// Hardware sequencer for one NPU inference: drives conv, partial_sum and fcn
// handshakes so the host only issues start/abort and reads status.
module npu_layer_sequencer #(
  parameter int CONV_PIX   = npu_pkg::CONV_PIX,
  parameter int NUM_CH     = npu_pkg::NUM_CH,
  parameter int FC1_GROUPS = npu_pkg::FC1_GROUPS,
  parameter int TIMEOUT    = npu_pkg::TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] state_o,
  output logic [3:0] ch_idx,
  output logic       conv_clear,
  output logic       conv_trigger,
  output logic       conv_layer,
  input  logic       conv_valid,
  output logic       conv_save_done,
  output logic       sum_clear,
  output logic       wbuf_req,
  input  logic       wbuf_ack,
  output logic       fcn_start,
  output logic       fcn_fc1_next,
  input  logic       fcn_fc1_valid,
  input  logic       fcn_done
);
  import npu_pkg::*;

  localparam int PW = $clog2(CONV_PIX + 1);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam int GW = $clog2(FC1_GROUPS + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(CONV_PIX - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(FC1_GROUPS - 1);

  seq_state_e    state, state_base, state_nx;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] ch_cnt;
  logic [GW-1:0] grp_cnt;
  logic          hs, kick, expire, run_st;

  assign run_st = (state == C1_RUN) || (state == C2_RUN);

  // state_base is the handshake-driven path; abort and watchdog override it
  always_comb begin
    state_base = state;
    hs         = 1'b0;
    case (state)
      IDLE:     if (start) state_base = C1_RUN;
      C1_RUN, C2_RUN:
        if (conv_valid) begin
          hs = 1'b1;
          if (pix_cnt == PIX_LAST) state_base = (state == C1_RUN) ? C1_SAVE : C2_SAVE;
        end
      C1_SAVE:  state_base = C2_CLR;
      C2_CLR:   state_base = C2_RUN;
      C2_SAVE:  state_base = (ch_cnt == CH_LAST) ? FC_START : C2_RUN;
      FC_START: state_base = FC_LOAD;
      FC_LOAD:
        if (wbuf_ack) begin
          hs         = 1'b1;
          state_base = FC_STEP;
        end
      FC_STEP:  state_base = FC_WAIT;
      FC_WAIT:
        if (fcn_fc1_valid) begin
          hs         = 1'b1;
          state_base = (grp_cnt == GRP_LAST) ? FC_FIN : FC_LOAD;
        end
      FC_FIN:
        if (fcn_done) begin
          hs         = 1'b1;
          state_base = DONE;
        end
      DONE:     state_base = IDLE;
      ERR:      if (start) state_base = C1_RUN;
      default:  state_base = IDLE;
    endcase
  end

  assign kick     = abort || hs || (state_base != state);
  assign state_nx = abort ? IDLE : (expire ? ERR : state_base);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst_ni (rst_ni),
    .enable (busy),
    .kick   (kick),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      ch_cnt       <= '0;
      grp_cnt      <= '0;
      conv_layer   <= 1'b0;
      conv_trigger <= 1'b0;
    end else begin
      state        <= state_nx;
      conv_trigger <= ((state_nx == C1_RUN) || (state_nx == C2_RUN)) && !run_st;
      if (abort || expire || !busy) begin
        pix_cnt    <= '0;
        ch_cnt     <= '0;
        grp_cnt    <= '0;
        conv_layer <= 1'b0;
      end else begin
        if (run_st && conv_valid)
          pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
        if (state == C1_SAVE) conv_layer <= 1'b1;
        if (state == C2_SAVE) begin
          if (ch_cnt == CH_LAST) begin
            ch_cnt     <= '0;
            conv_layer <= 1'b0;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        if ((state == FC_WAIT) && fcn_fc1_valid) grp_cnt <= grp_cnt + 1'b1;
      end
    end
  end

  // single-cycle states make every other pulse a pure state decode
  assign busy           = (state != IDLE) && (state != ERR);
  assign err            = (state == ERR);
  assign done           = (state == DONE);
  assign state_o        = state;
  assign ch_idx         = 4'(ch_cnt);
  assign conv_clear     = (state == IDLE) || (state == ERR) || (state == C2_CLR) ||
                          ((state == C2_SAVE) && (ch_cnt != CH_LAST));
  assign conv_save_done = (state == C1_SAVE) || (state == C2_SAVE);
  assign sum_clear      = (state == C2_CLR);
  assign fcn_start      = (state == FC_START);
  assign wbuf_req       = (state == FC_LOAD);
  assign fcn_fc1_next   = (state == FC_STEP);
endmodule
